// File: rtl/alu_seq.sv
// Sequential ALU: 4-entry register file, single-cycle logic/arith/LDI ops,
// and a W-cycle shift-add multiplier, with valid/ready command and result handshakes.
module alu_seq #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_op,
  input  logic [1:0]   in_rd,
  input  logic [1:0]   in_rs,
  input  logic [1:0]   in_rt,
  input  logic [W-1:0] in_imm,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic         res_cout,
  output logic         res_err
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;
  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_LDI = 3'b100,
    OP_MUL = 3'b101
  } op_t;

  state_t         r_state;
  logic [W-1:0]   r_rf [4];
  logic [2:0]     r_op;
  logic [1:0]     r_rd;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [W-1:0]   r_imm;
  logic [CW-1:0]  r_cnt;
  logic [2*W-1:0] r_acc;
  logic [2*W-1:0] r_mcand;
  logic [W-1:0]   r_mplier;
  logic           r_res_valid;
  logic [W-1:0]   r_res_data;
  logic           r_res_cout;
  logic           r_res_err;

  logic [W-1:0]   w_res;
  logic           w_cout;
  logic           w_err;
  logic           w_wr;
  logic [2*W-1:0] w_acc_next;

  assign in_ready  = (r_state == S_IDLE);
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_cout  = r_res_cout;
  assign res_err   = r_res_err;

  // One partial product per cycle: multiplicand shifts up, multiplier shifts down.
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_comb begin
    w_res  = '0;
    w_cout = 1'b0;
    w_err  = 1'b0;
    w_wr   = 1'b1;
    case (r_op)
      OP_AND: w_res = r_a & r_b;
      OP_OR:  w_res = r_a | r_b;
      OP_ADD: {w_cout, w_res} = {1'b0, r_a} + {1'b0, r_b};
      OP_SUB: {w_cout, w_res} = {1'b0, r_a} + {1'b0, ~r_b} + (W + 1)'(1);
      OP_LDI: w_res = r_imm;
      OP_MUL: w_wr = 1'b0;
      default: begin
        w_err = 1'b1;
        w_wr  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      for (int unsigned i = 0; i < 4; i++) r_rf[i] <= '0;
      r_op        <= '0;
      r_rd        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_imm       <= '0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_cout  <= 1'b0;
      r_res_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op     <= in_op;
            r_rd     <= in_rd;
            r_a      <= r_rf[in_rs];
            r_b      <= r_rf[in_rt];
            r_imm    <= in_imm;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= {{W{1'b0}}, r_rf[in_rs]};
            r_mplier <= r_rf[in_rt];
            r_state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_op == OP_MUL) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
            if (r_cnt == CNT_LAST) begin
              r_rf[r_rd]  <= w_acc_next[W-1:0];
              r_res_data  <= w_acc_next[W-1:0];
              r_res_cout  <= |w_acc_next[2*W-1:W];
              r_res_err   <= 1'b0;
              r_res_valid <= 1'b1;
              r_state     <= S_RESP;
            end
          end else begin
            if (w_wr) r_rf[r_rd] <= w_res;
            r_res_data  <= w_res;
            r_res_cout  <= w_cout;
            r_res_err   <= w_err;
            r_res_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: driver pushes model predictions, monitor pops on results.
module tb_alu_seq;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic [1:0]   in_rd, in_rs, in_rt;
  logic [W-1:0] in_imm;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic         res_cout;
  logic         res_err;

  alu_seq #(.W(W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_cout(res_cout), .res_err(res_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        cout;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model[4];
  int          nchk = 0;
  int          nerr = 0;
  int          ncyc = 0;
  int          acc_cyc = -1;
  int          hs_cyc = -1;
  int          rr_mode = 1;
  bit          pend_done = 0;

  task automatic check(input string name, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain arithmetic on the operand values.
  function automatic exp_t predict(input logic [2:0] op, input logic [15:0] a,
                                   input logic [15:0] b, input logic [15:0] imm);
    exp_t e;
    int unsigned ia, ib, s;
    ia = a;
    ib = b;
    e.data = '0; e.cout = 1'b0; e.err = 1'b0; e.lat = 1;
    case (op)
      3'd0: e.data = a & b;
      3'd1: e.data = a | b;
      3'd2: begin s = ia + ib; e.data = 16'(s); e.cout = (s > 32'hFFFF); end
      3'd3: begin e.data = 16'(ia - ib); e.cout = (ia >= ib); end
      3'd4: e.data = imm;
      3'd5: begin s = ia * ib; e.data = 16'(s); e.cout = ((s >> 16) != 0); e.lat = 16; end
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  task automatic send(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                      input logic [1:0] rt, input logic [15:0] imm,
                      input bit fixed = 0, input logic [15:0] fdata = '0,
                      input logic fcout = 1'b0);
    exp_t e;
    int unsigned n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs = rs; in_rt = rt; in_imm = imm;
    @(negedge clk);
    while (!in_ready) begin
      n++;
      if (n > 200) begin
        check("accept_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    e = predict(op, model[rs], model[rt], imm);
    if (fixed) begin
      e.data = fdata;
      e.cout = fcout;
    end
    if (op <= 3'd5) model[rd] = e.data;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic read_reg(input logic [1:0] i, input logic [15:0] exp);
    send(3'd1, i, i, i, 16'h0, 1, exp, 1'b0);
  endtask

  task automatic drain();
    int unsigned n = 0;
    while ((sb.size() != 0 || res_valid) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", int'(n < 1000), 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_res_data", int'(res_data), 0);
    check("rst_res_cout", int'(res_cout), 0);
    check("rst_res_err", int'(res_err), 0);
    sb.delete();
    for (int i = 0; i < 4; i++) model[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("in_ready_after_reset", int'(in_ready), 1);
  endtask

  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rr_mode)
        0: res_ready = 1'($urandom_range(0, 1));
        1: res_ready = 1'b1;
        default: res_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pop on the first cycle of each result, then demand stability until handshake.
  initial begin
    exp_t        e;
    logic [15:0] hd;
    logic        hc, he;
    bit          prev = 0;
    hd = '0; hc = 1'b0; he = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 0;
        continue;
      end
      ncyc++;
      if (in_valid && in_ready) acc_cyc = ncyc;
      if (res_valid) begin
        check("in_ready_low_in_resp", int'(in_ready), 0);
        if (!prev) begin
          if (sb.size() == 0) check("unexpected_result", 1, 0);
          else begin
            e = sb.pop_front();
            check("res_data", int'(res_data), int'(e.data));
            check("res_cout", int'(res_cout), int'(e.cout));
            check("res_err", int'(res_err), int'(e.err));
            check("latency", ncyc - acc_cyc - 1, e.lat);
          end
          hd = res_data; hc = res_cout; he = res_err;
        end else begin
          check("stable_data", int'(res_data), int'(hd));
          check("stable_cout", int'(res_cout), int'(hc));
          check("stable_err", int'(res_err), int'(he));
        end
        if (res_ready) hs_cyc = ncyc;
        prev = !res_ready;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", nerr);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    int          acc_before;
    int unsigned r;
    logic [2:0]  op;
    reset = 1'b1;
    in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs = '0; in_rt = '0; in_imm = '0;
    for (int i = 0; i < 4; i++) model[i] = '0;
    do_reset();

    // ADD wrap with carry
    send(3'd4, 2'd1, 2'd0, 2'd0, 16'hFFFF);
    send(3'd4, 2'd2, 2'd0, 2'd0, 16'h0001);
    send(3'd2, 2'd3, 2'd1, 2'd2, 16'h0, 1, 16'h0000, 1'b1);
    read_reg(2'd3, 16'h0000);

    // SUB borrow and no-borrow
    send(3'd4, 2'd1, 2'd0, 2'd0, 16'h0005);
    send(3'd4, 2'd2, 2'd0, 2'd0, 16'h0007);
    send(3'd3, 2'd0, 2'd1, 2'd2, 16'h0, 1, 16'hFFFE, 1'b0);
    send(3'd3, 2'd0, 2'd2, 2'd1, 16'h0, 1, 16'h0002, 1'b1);

    // MUL overflow and small product
    send(3'd4, 2'd1, 2'd0, 2'd0, 16'h0100);
    send(3'd4, 2'd2, 2'd0, 2'd0, 16'h0100);
    send(3'd5, 2'd3, 2'd1, 2'd2, 16'h0, 1, 16'h0000, 1'b1);
    send(3'd4, 2'd1, 2'd0, 2'd0, 16'h0003);
    send(3'd4, 2'd2, 2'd0, 2'd0, 16'h0005);
    send(3'd5, 2'd0, 2'd1, 2'd2, 16'h0, 1, 16'h000F, 1'b0);
    send(3'd5, 2'd1, 2'd1, 2'd1, 16'h0, 1, 16'h0009, 1'b0);
    drain();

    // Result backpressure with a pending command
    rr_mode = 2;
    send(3'd4, 2'd2, 2'd0, 2'd0, 16'h1234);
    n = 0;
    while (!res_valid && n < 50) begin @(negedge clk); n++; end
    check("bp_result_seen", int'(res_valid), 1);
    acc_before = acc_cyc;
    pend_done = 0;
    fork
      begin
        send(3'd4, 2'd3, 2'd0, 2'd0, 16'h5678);
        pend_done = 1;
      end
    join_none
    repeat (5) @(negedge clk);
    check("bp_no_accept", acc_cyc, acc_before);
    check("bp_in_ready_low", int'(in_ready), 0);
    rr_mode = 1;
    n = 0;
    while (!pend_done && n < 50) begin @(negedge clk); n++; end
    check("bp_pending_done", int'(pend_done), 1);
    check("bp_accept_cycle", acc_cyc, hs_cyc + 1);
    drain();
    read_reg(2'd2, 16'h1234);
    read_reg(2'd3, 16'h5678);
    drain();

    // Reset in the middle of a MUL
    send(3'd4, 2'd1, 2'd0, 2'd0, 16'h00FF);
    send(3'd5, 2'd0, 2'd1, 2'd1, 16'h0);
    repeat (7) @(posedge clk);
    do_reset();
    for (int i = 0; i < 4; i++) read_reg(2'(i), 16'h0000);
    send(3'd4, 2'd2, 2'd0, 2'd0, 16'hBEEF, 1, 16'hBEEF, 1'b0);
    read_reg(2'd2, 16'hBEEF);
    drain();

    // Reserved opcode leaves registers untouched
    send(3'd4, 2'd0, 2'd0, 2'd0, 16'h1111);
    send(3'd4, 2'd1, 2'd0, 2'd0, 16'h2222);
    send(3'd4, 2'd3, 2'd0, 2'd0, 16'h4444);
    send(3'd7, 2'd1, 2'd0, 2'd3, 16'hAAAA);
    send(3'd6, 2'd2, 2'd1, 2'd1, 16'h5555);
    read_reg(2'd0, 16'h1111);
    read_reg(2'd1, 16'h2222);
    read_reg(2'd2, 16'hBEEF);
    read_reg(2'd3, 16'h4444);
    drain();

    // Randomized traffic with random result backpressure
    rr_mode = 0;
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 15);
      op = (r < 14) ? 3'(r % 6) : 3'(6 + (r - 14));
      send(op, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), 16'($urandom));
    end
    drain();
    rr_mode = 1;
    for (int i = 0; i < 4; i++) read_reg(2'(i), model[i]);
    drain();
    check("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
